// File: rtl/regfile_banked.sv
// rtl/regfile_banked.sv - banked multi-read-port register file with toggle-token write guard
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_banked #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_BANKS = 2,
    parameter int NUM_READ  = 2,
    parameter int ZERO_REG  = 1,
    localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                         CLK,
    input  logic                         reset_n,
    input  logic                         stall,
    input  logic [NUM_READ*BW-1:0]       rd_bank,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    input  logic                         wr_en,
    input  logic                         wr_token,
    input  logic [BW-1:0]                wr_bank,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         wr_ack
);

    localparam int             DEPTH      = 2 ** ADDR_W;
    localparam logic [BW:0]    BANK_LIMIT = (BW + 1)'(NUM_BANKS);

    logic [DATA_W-1:0]          mem [NUM_BANKS][DEPTH];
    logic                       token_q;
    logic                       ack_q;
    logic [NUM_READ*DATA_W-1:0] rd_q;
    logic [NUM_READ*DATA_W-1:0] rd_next;
    logic                       wr_commit;
    logic                       wr_store;

    function automatic logic bank_ok(input logic [BW-1:0] b);
        return ({1'b0, b} < BANK_LIMIT);
    endfunction

    function automatic logic is_zero(input logic [BW-1:0] b, input logic [ADDR_W-1:0] a);
        return (ZERO_REG == 1) && (b == '0) && (a == '0);
    endfunction

    // A held request only commits once: the token must differ from the last one consumed.
    assign wr_commit = wr_en && (wr_token != token_q);
    assign wr_store  = wr_commit && bank_ok(wr_bank) && !is_zero(wr_bank, wr_addr);

    always_comb begin
        rd_next = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (bank_ok(rd_bank[p*BW +: BW]) &&
                !is_zero(rd_bank[p*BW +: BW], rd_addr[p*ADDR_W +: ADDR_W])) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_store && (rd_bank[p*BW +: BW] == wr_bank) &&
                    (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr)) begin
                    rd_next[p*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_next[p*DATA_W +: DATA_W] =
                        mem[rd_bank[p*BW +: BW]][rd_addr[p*ADDR_W +: ADDR_W]];
                end
`else
                rd_next[p*DATA_W +: DATA_W] =
                    mem[rd_bank[p*BW +: BW]][rd_addr[p*ADDR_W +: ADDR_W]];
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 0; r < DEPTH; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (wr_store) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Ignored targets (zero reg, missing bank) still consume the token and acknowledge.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            token_q <= 1'b1;
            ack_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            ack_q <= wr_commit;
            if (wr_commit) begin
                token_q <= wr_token;
            end
            if (!stall) begin
                rd_q <= rd_next;
            end
        end
    end

    assign rd_data = rd_q;
    assign wr_ack  = ack_q;

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
Parametrised multi-bank, multi-read-port register file for the CPU core. It generalises the fixed integer/float pair into NUM_BANKS banks (bank 0 = integer, bank 1 = float, further banks reserved for future units) and NUM_READ registered read ports. It keeps the toggle-token write guard, so a write held across multiple cycles commits exactly once. It sits between decode (read side) and writeback/UART-load (write side).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; each bank holds 2**ADDR_W registers
NUM_BANKS, 2, number of register banks (>=1)
NUM_READ, 2, number of read ports (>=1)
ZERO_REG, 1, if 1 then bank 0 register 0 always reads 0 and ignores writes

Ports:
CLK  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  1 = hold all rd_data outputs
rd_bank  input  NUM_READ*BW  per-port bank select, BW = max(1,$clog2(NUM_BANKS)), port i in bits [i*BW +: BW]
rd_addr  input  NUM_READ*ADDR_W  per-port register index, port i in bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_READ*DATA_W  registered read data, port i in bits [i*DATA_W +: DATA_W]
wr_en  input  1  write request (RegWrite OR UART write)
wr_token  input  1  toggle token; a new write is signalled by a token different from the last committed one
wr_bank  input  BW  bank of write target
wr_addr  input  ADDR_W  register index of write target
wr_data  input  DATA_W  write data
wr_ack  output  1  one-cycle pulse, registered, the cycle after a write commits

Behaviour:
- Reset (reset_n=0, asynchronous): every register in every bank = 0; rd_data = 0; wr_ack = 0; internal token_q = 1. Reset asserted mid-write aborts the write; no partial state survives.
- Read latency 1 cycle: at a rising edge with stall=0, rd_data[i] <= bank[rd_bank[i]][rd_addr[i]] for every port independently. With stall=1, rd_data holds its value.
- rd_bank >= NUM_BANKS: that port loads 0.
- ZERO_REG=1 and port selects bank 0 reg 0: loads 0 regardless of array contents.
- Write commit condition: wr_en=1 AND wr_token != token_q. On commit: token_q <= wr_token; wr_ack <= 1; bank[wr_bank][wr_addr] <= wr_data unless wr_bank >= NUM_BANKS or (ZERO_REG=1, bank 0, addr 0). The token is still consumed and wr_ack still pulses in those ignored cases.
- No commit in a cycle: wr_ack <= 0, token_q unchanged. wr_en held high with an unchanged token writes only once.
- stall does not affect writes.
- Same-cycle read and write to the same register: without the optional feature, the read returns the pre-write value.
- Multiple read ports may address the same register; all return the same value.

Optional Feature:
REGFILE_BYPASS_EN. Defined: a read port that captures (stall=0) in the same cycle as a committing write with matching bank and addr loads wr_data instead of the stored value. The ZERO_REG and out-of-range-bank rules still take priority (result 0). Undefined: no forwarding; old value returned as above.

Test Plan:
- Reset: drive reset_n=0 asynchronously mid-cycle -> rd_data=0 immediately, wr_ack=0; after release, read bank0/reg5 and bank1/reg5 -> both 0.
- Write/read: token 0, wr_en=1, bank1 reg3 = 0x3F800000 -> wr_ack=1 the next cycle. Port0 bank1 reg3 reads 0x3F800000; port1 bank0 reg3 reads 0.
- Token guard: hold wr_en=1 with token 0 for 4 cycles while wr_data changes 0x11, 0x22, ... -> exactly one wr_ack pulse; the register holds 0x11. Toggle token to 1 with data 0x99 -> register becomes 0x99 and a second wr_ack pulses.
- Zero register: write 0xDEADBEEF to bank0 reg0 -> wr_ack=1, read returns 0. The same write to bank1 reg0 reads back 0xDEADBEEF.
- Stall: rd_data port0 = 0x5; assert stall and change rd_addr to a reg holding 0x7 -> rd_data stays 0x5 until stall drops, then 0x7 one cycle later.
- Same-cycle hazard: bank0 reg4 = 0x1; write 0x2 to it while port0 reads it -> port0 = 0x1 without REGFILE_BYPASS_EN, 0x2 with it. The next read is 0x2 in both builds.
